// File: rtl/sample_player_if.sv
// Bus bundle between the host-side write/control source and the sample player.
// The master drives RAM writes and playback controls; the slave (player)
// returns the sample stream, read address and wrap pulse.
interface sample_player_if #(
    parameter int OUTPUT_WIDTH = 16,
    parameter int ADDR_WIDTH   = 12
);
    logic                    enable;
    logic                    wr_enable;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [OUTPUT_WIDTH-1:0] wr_data;
    logic [ADDR_WIDTH-1:0]   step;
    logic [ADDR_WIDTH-1:0]   range;
    logic [OUTPUT_WIDTH-1:0] sample_out;
    logic                    sample_valid;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic                    wrap;

    modport master (
        output enable, wr_enable, wr_addr, wr_data, step, range,
        input  sample_out, sample_valid, rd_addr, wrap
    );

    modport slave (
        input  enable, wr_enable, wr_addr, wr_data, step, range,
        output sample_out, sample_valid, rd_addr, wrap
    );
endinterface

// File: rtl/sample_player.sv
// Sample player: a host-written sample RAM replayed at a fixed tick rate.
// Every TICK_DIV clocks the word at rd_addr is read; the read address then
// advances by step and wraps back past range. Read latency is two clocks
// from the tick to the registered sample_out / sample_valid pulse.
module sample_player #(
    parameter int OUTPUT_WIDTH = 16,
    parameter int ADDR_WIDTH   = 12,
    parameter int TICK_DIV     = 1042
) (
    input  logic            clk,
    input  logic            reset_n,
    sample_player_if.slave  bus
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam int EXT_W = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        tick_cnt;
    logic [ADDR_WIDTH-1:0]   rd_addr_q;
    logic [OUTPUT_WIDTH-1:0] sample_q;
    logic                    valid_q;
    logic                    wrap_q;
    logic                    rd_pending;
    logic [OUTPUT_WIDTH-1:0] rd_data;
    logic [OUTPUT_WIDTH-1:0] mem [DEPTH];

    logic                    tick;
    logic [EXT_W-1:0]        sum_ext;
    logic [EXT_W-1:0]        range_ext;
    logic [EXT_W-1:0]        folded;
    logic [ADDR_WIDTH-1:0]   next_addr;
    logic                    next_wrap;

    assign tick = (state == RUN) && bus.enable && (tick_cnt == CNT_W'(TICK_DIV - 1));

    // Next read address: extended-width sum, folded once past range, forced
    // to 0 when a single fold still lands beyond range (step > range).
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        next_addr = '0;
        next_wrap = 1'b0;
        sum_ext   = {1'b0, rd_addr_q} + {1'b0, bus.step};
        range_ext = {1'b0, bus.range};
        folded    = sum_ext - range_ext - EXT_W'(1);
        if (sum_ext <= range_ext) begin
            next_addr = sum_ext[ADDR_WIDTH-1:0];
        end else begin
            next_wrap = 1'b1;
            if (folded > range_ext) begin
                next_addr = '0;
            end else begin
                next_addr = folded[ADDR_WIDTH-1:0];
            end
        end
    end

    // Sample RAM: writes in any state, read-first synchronous read on tick.
    // NOTE: the array and its read register have no reset so they map onto block RAM; contents survive reset.
    always_ff @(posedge clk) begin
        if (bus.wr_enable) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
        if (tick) begin
            rd_data <= mem[rd_addr_q];
        end
    end

    // Playback FSM with tick counter, address stepping and output registers.
    // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            rd_addr_q  <= '0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
            wrap_q     <= 1'b0;
            rd_pending <= 1'b0;
        end else begin
            valid_q    <= rd_pending;
            rd_pending <= 1'b0;
            wrap_q     <= 1'b0;
            if (rd_pending) begin
                sample_q <= rd_data;
            end
            case (state)
                IDLE: begin
                    tick_cnt  <= '0;
                    rd_addr_q <= '0;
                    if (bus.enable) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!bus.enable) begin
                        state     <= IDLE;
                        tick_cnt  <= '0;
                        rd_addr_q <= '0;
                    end else if (tick) begin
                        tick_cnt   <= '0;
                        rd_pending <= 1'b1;
                        rd_addr_q  <= next_addr;
                        wrap_q     <= next_wrap;
                    end else begin
                        tick_cnt <= tick_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.sample_out   = sample_q;
    assign bus.sample_valid = valid_q;
    assign bus.rd_addr      = rd_addr_q;
    assign bus.wrap         = wrap_q;

endmodule

// File: tb/tb_sample_player.sv
// Self-checking bench for sample_player: table of per-tick address/wrap
// expectations, a scoreboard of expected samples with due cycles, and
// hand-written sequences for write collision and mid-run reset.
module tb_sample_player;

    localparam int OW = 16;
    localparam int AW = 12;
    localparam int TD = 4;

    typedef struct {
        logic          restart;
        logic          collide;
        logic [AW-1:0] step;
        logic [AW-1:0] rng;
        logic [OW-1:0] wdata;
        logic [AW-1:0] exp_addr;
        logic          exp_wrap;
    } vec_t;

    typedef struct {
        logic [OW-1:0] data;
        int            due;
    } sb_t;

    logic clk;
    logic reset_n;

    sample_player_if #(.OUTPUT_WIDTH(OW), .ADDR_WIDTH(AW)) bus ();

    sample_player #(.OUTPUT_WIDTH(OW), .ADDR_WIDTH(AW), .TICK_DIV(TD)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int            n_vec = 0;
    int            n_err = 0;
    int            cyc = 0;
    logic [OW-1:0] shadow [1 << AW];
    logic [AW-1:0] model_addr;
    logic [OW-1:0] last_sample;
    logic          running;
    sb_t           sb_q [$];
    vec_t          vecs [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard consumer: every sample_valid must match the oldest expected sample and its due cycle.
    always @(negedge clk) begin
        if (bus.sample_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("spurious_valid", 32'(bus.sample_valid), 32'd0);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                check("sample_out", 32'(bus.sample_out), 32'(e.data));
                check("valid_cycle", 32'(cyc), 32'(e.due));
                last_sample = e.data;
            end
        end
    end

    function automatic void add_row(input logic rs, input logic [AW-1:0] st, input logic [AW-1:0] rg,
                                    input logic [AW-1:0] ea, input logic ew);
        vec_t v;
        v.restart  = rs;
        v.collide  = 1'b0;
        v.step     = st;
        v.rng      = rg;
        v.wdata    = '0;
        v.exp_addr = ea;
        v.exp_wrap = ew;
        vecs.push_back(v);
    endfunction

    task automatic write_word(input logic [AW-1:0] a, input logic [OW-1:0] d);
        @(negedge clk);
        bus.wr_enable = 1'b1;
        bus.wr_addr   = a;
        bus.wr_data   = d;
        @(posedge clk);
        #1;
        bus.wr_enable = 1'b0;
        shadow[a] = d;
    endtask

    // Called #1 after an edge; the following edge is the one that enters RUN.
    task automatic start_play();
        bus.enable = 1'b1;
        @(posedge clk);
        model_addr = '0;
        running    = 1'b1;
    endtask

    // Called #1 after a tick's T+1 edge: drop enable one cycle after the tick.
    task automatic stop_play();
        bus.enable = 1'b0;
        @(posedge clk);
        #1;
        check("stop_rd_addr", 32'(bus.rd_addr), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("idle_rd_addr", 32'(bus.rd_addr), 32'd0);
        check("idle_hold_out", 32'(bus.sample_out), 32'(last_sample));
        check("idle_drained", 32'(sb_q.size()), 32'd0);
        running = 1'b0;
    endtask

    // Waits from a reference edge to the tick cycle, optionally writes the
    // tick address in that cycle, then checks rd_addr/wrap after the T+1 edge.
    task automatic do_tick(input vec_t v);
        sb_t e;
        repeat (TD - 1) @(posedge clk);
        #1;
        if (v.collide) begin
            bus.wr_enable = 1'b1;
            bus.wr_addr   = model_addr;
            bus.wr_data   = v.wdata;
        end
        e.data = shadow[model_addr];
        e.due  = cyc + 2;
        sb_q.push_back(e);
        if (v.collide) shadow[model_addr] = v.wdata;
        @(posedge clk);
        #1;
        bus.wr_enable = 1'b0;
        check("rd_addr", 32'(bus.rd_addr), 32'(v.exp_addr));
        check("wrap", 32'(bus.wrap), 32'(v.exp_wrap));
        model_addr = v.exp_addr;
    endtask

    initial begin
        vec_t v;
        reset_n       = 1'b0;
        running       = 1'b0;
        last_sample   = '0;
        model_addr    = '0;
        bus.enable    = 1'b0;
        bus.wr_enable = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.step      = '0;
        bus.range     = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_sample_out", 32'(bus.sample_out), 32'd0);
        check("rst_valid", 32'(bus.sample_valid), 32'd0);
        check("rst_wrap", 32'(bus.wrap), 32'd0);
        check("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Fill RAM while disabled
        for (int i = 0; i < 16; i++) write_word(AW'(i), OW'(16'h1000 + i));
        for (int i = 4093; i < 4096; i++) write_word(AW'(i), OW'(16'hA000 + i));

        // Per-tick table: {restart, step, range, expected next rd_addr, expected wrap}
        add_row(1'b1, 12'd1, 12'd7, 12'd1, 1'b0);
        for (int i = 2; i <= 7; i++) add_row(1'b0, 12'd1, 12'd7, AW'(i), 1'b0);
        add_row(1'b0, 12'd1, 12'd7, 12'd0, 1'b1);
        for (int i = 1; i <= 5; i++) add_row(1'b0, 12'd1, 12'd7, AW'(i), 1'b0);
        add_row(1'b0, 12'd1, 12'd3, 12'd2, 1'b1);       // range lowered below rd_addr
        add_row(1'b1, 12'd3, 12'd9, 12'd3, 1'b0);
        add_row(1'b0, 12'd3, 12'd9, 12'd6, 1'b0);
        add_row(1'b0, 12'd3, 12'd9, 12'd9, 1'b0);
        add_row(1'b0, 12'd3, 12'd9, 12'd2, 1'b1);
        add_row(1'b0, 12'd3, 12'd9, 12'd5, 1'b0);
        add_row(1'b0, 12'd3, 12'd9, 12'd8, 1'b0);
        add_row(1'b0, 12'd3, 12'd9, 12'd1, 1'b1);
        add_row(1'b0, 12'd3, 12'd9, 12'd4, 1'b0);
        add_row(1'b0, 12'd3, 12'd9, 12'd7, 1'b0);
        add_row(1'b0, 12'd3, 12'd9, 12'd0, 1'b1);
        for (int i = 0; i < 3; i++) add_row(i == 0, 12'd6, 12'd2, 12'd0, 1'b1);   // fold still > range
        for (int i = 0; i < 2; i++) add_row(i == 0, 12'd0, 12'd5, 12'd0, 1'b0);   // step 0 holds
        for (int i = 0; i < 2; i++) add_row(i == 0, 12'd1, 12'd0, 12'd0, 1'b1);   // range 0
        add_row(1'b1, 12'd4095, 12'd4095, 12'd4095, 1'b0);                         // full-width sum
        add_row(1'b0, 12'd4095, 12'd4095, 12'd4094, 1'b1);
        add_row(1'b0, 12'd4095, 12'd4095, 12'd4093, 1'b1);

        foreach (vecs[i]) begin
            v = vecs[i];
            bus.step  = v.step;
            bus.range = v.rng;
            if (v.restart) begin
                if (running) stop_play();
                start_play();
            end
            do_tick(v);
        end
        stop_play();

        // Read-first collision at the tick address, then revisit it
        write_word(12'd0, 16'h1234);
        bus.step  = 12'd1;
        bus.range = 12'd7;
        start_play();
        for (int i = 1; i <= 9; i++) begin
            v.restart  = 1'b0;
            v.collide  = (i == 1);
            v.step     = 12'd1;
            v.rng      = 12'd7;
            v.wdata    = 16'hBEEF;
            v.exp_addr = AW'(i % 8);
            v.exp_wrap = (i == 8);
            do_tick(v);
        end

        // Asynchronous reset between edges with a read in flight
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_sample_out", 32'(bus.sample_out), 32'd0);
        check("mid_rst_valid", 32'(bus.sample_valid), 32'd0);
        check("mid_rst_wrap", 32'(bus.wrap), 32'd0);
        check("mid_rst_rd_addr", 32'(bus.rd_addr), 32'd0);
        sb_q.delete();
        last_sample = '0;
        bus.enable  = 1'b0;
        running     = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;

        // Replay proves RAM survived reset
        start_play();
        for (int i = 1; i <= 8; i++) begin
            v.restart  = 1'b0;
            v.collide  = 1'b0;
            v.step     = 12'd1;
            v.rng      = 12'd7;
            v.wdata    = '0;
            v.exp_addr = AW'(i % 8);
            v.exp_wrap = (i == 8);
            do_tick(v);
        end
        stop_play();

        check("sb_empty_at_end", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
